// File: rtl/fc_input_packer.sv
// fc_input_packer
// Flatten stage between the pooling layer and the fully connected layer.
// Each accepted frame pulse latches one pooled channel map. The active
// height x width region is copied in row-major order, one element per
// cycle, into an INPUT_SIZE-byte packing vector. Once num_frames frames
// have been packed, the vector is published on vec_out and vec_valid
// pulses for one cycle.
//
// Optional feature macro: PACKER_RELU_EN (negative elements written as 0).
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   frame_valid_in one-cycle frame pulse (data and dims valid this cycle)
//   frame_data_in  frame map, element (r,c) at [(r*MAX_IMG_WIDTH+c)*ELEM_WIDTH +: ELEM_WIDTH]
//   frame_height   active rows
//   frame_width    active columns
//   num_frames     frames per output vector (0 is treated as 1)
//   frame_ready    high when a frame pulse will be accepted
//   vec_valid      one-cycle pulse, vec_out updated
//   vec_out        packed int8 vector, element k at [k*8 +: 8]
//   overflow       sticky: elements dropped because the vector was full
//   frame_drop     sticky: frame pulse arrived while frame_ready was low
module fc_input_packer #(
    parameter int ELEM_WIDTH     = 8,
    parameter int MAX_IMG_HEIGHT = 32,
    parameter int MAX_IMG_WIDTH  = 32,
    parameter int INPUT_SIZE     = 128
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            frame_valid_in,
    input  logic [MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] frame_data_in,
    input  logic [7:0]                                      frame_height,
    input  logic [7:0]                                      frame_width,
    input  logic [7:0]                                      num_frames,
    output logic                                            frame_ready,
    output logic                                            vec_valid,
    output logic [INPUT_SIZE*8-1:0]                         vec_out,
    output logic                                            overflow,
    output logic                                            frame_drop
);

    localparam int FRAME_W = MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;
    localparam int VEC_W   = INPUT_SIZE * 8;
    localparam int WP_W    = $clog2(INPUT_SIZE + 1);
    localparam int IDX_W   = $clog2(FRAME_W) + 1;

    localparam logic [7:0] H_MAX = 8'(MAX_IMG_HEIGHT);
    localparam logic [7:0] W_MAX = 8'(MAX_IMG_WIDTH);
    localparam logic signed [ELEM_WIDTH-1:0] SAT_HI = ELEM_WIDTH'(127);
    localparam logic signed [ELEM_WIDTH-1:0] SAT_LO = ELEM_WIDTH'(-128);

    typedef enum logic [1:0] {IDLE, LOAD, NEXT, EMIT} state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [7:0]           height_q, height_d;
    logic [7:0]           width_q, width_d;
    logic [7:0]           nframes_q, nframes_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic [7:0]           r_q, r_d;
    logic [7:0]           c_q, c_d;
    logic [WP_W-1:0]      wp_q, wp_d;
    logic [VEC_W-1:0]     pack_q, pack_d;
    logic [VEC_W-1:0]     vec_out_q, vec_out_d;
    logic                 vec_valid_q, vec_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_drop_q, frame_drop_d;

    logic                 ready;
    logic                 empty;
    logic                 last_elem;
    logic [IDX_W-1:0]     elem_base;
    logic [ELEM_WIDTH-1:0] elem;

    // Element to int8: optional ReLU first, then signed saturation
    // (saturation is a no-op when ELEM_WIDTH is 8).
    function automatic logic [7:0] conv(input logic [ELEM_WIDTH-1:0] x);
        logic signed [ELEM_WIDTH-1:0] v;
        v = $signed(x);
`ifdef PACKER_RELU_EN
        if (v[ELEM_WIDTH-1]) v = '0;
`endif
        if (v > SAT_HI)      return 8'h7F;
        else if (v < SAT_LO) return 8'h80;
        else                 return v[7:0];
    endfunction

    assign ready = (state_q == IDLE) || (state_q == NEXT);
    assign empty = (height_q == 8'd0) || (width_q == 8'd0);
    assign last_elem = empty ||
                       ((r_q == height_q - 8'd1) && (c_q == width_q - 8'd1));
    assign elem_base = ((IDX_W'(r_q) * IDX_W'(MAX_IMG_WIDTH)) + IDX_W'(c_q))
                       * IDX_W'(ELEM_WIDTH);
    assign elem = frame_q[elem_base +: ELEM_WIDTH];

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        height_d     = height_q;
        width_d      = width_q;
        nframes_d    = nframes_q;
        fcnt_d       = fcnt_q;
        r_d          = r_q;
        c_d          = c_q;
        wp_d         = wp_q;
        pack_d       = pack_q;
        vec_out_d    = vec_out_q;
        vec_valid_d  = 1'b0;
        overflow_d   = overflow_q;
        frame_drop_d = frame_drop_q;

        if (frame_valid_in && !ready) frame_drop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_valid_in) begin
                    frame_d      = frame_data_in;
                    height_d     = (frame_height > H_MAX) ? H_MAX : frame_height;
                    width_d      = (frame_width > W_MAX) ? W_MAX : frame_width;
                    nframes_d    = (num_frames == 8'd0) ? 8'd1 : num_frames;
                    fcnt_d       = 8'd0;
                    pack_d       = '0;
                    wp_d         = '0;
                    overflow_d   = 1'b0;
                    frame_drop_d = 1'b0;
                    r_d          = 8'd0;
                    c_d          = 8'd0;
                    state_d      = LOAD;
                end
            end
            NEXT: begin
                if (frame_valid_in) begin
                    frame_d = frame_data_in;
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!empty) begin
                    if (wp_q < WP_W'(INPUT_SIZE)) begin
                        pack_d[{wp_q, 3'b000} +: 8] = conv(elem);
                        wp_d = wp_q + WP_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (c_q == width_q - 8'd1) begin
                        c_d = 8'd0;
                        r_d = r_q + 8'd1;
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
                if (last_elem) begin
                    fcnt_d = fcnt_q + 8'd1;
                    if (fcnt_d == nframes_q) begin
                        if (empty) begin
                            // Nothing was written this cycle, so publish
                            // straight away: an empty final frame reaches
                            // vec_valid one cycle after its accept.
                            vec_out_d   = pack_q;
                            vec_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = EMIT;
                        end
                    end else begin
                        state_d = NEXT;
                    end
                end
            end
            EMIT: begin
                vec_out_d   = pack_q;
                vec_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            height_q     <= 8'd0;
            width_q      <= 8'd0;
            nframes_q    <= 8'd0;
            fcnt_q       <= 8'd0;
            r_q          <= 8'd0;
            c_q          <= 8'd0;
            wp_q         <= '0;
            pack_q       <= '0;
            vec_out_q    <= '0;
            vec_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            height_q     <= height_d;
            width_q      <= width_d;
            nframes_q    <= nframes_d;
            fcnt_q       <= fcnt_d;
            r_q          <= r_d;
            c_q          <= c_d;
            wp_q         <= wp_d;
            pack_q       <= pack_d;
            vec_out_q    <= vec_out_d;
            vec_valid_q  <= vec_valid_d;
            overflow_q   <= overflow_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign frame_ready = ready;
    assign vec_valid   = vec_valid_q;
    assign vec_out     = vec_out_q;
    assign overflow    = overflow_q;
    assign frame_drop  = frame_drop_q;

endmodule
